// File: rtl/vga_pkg.sv
`default_nettype none
// =============================================================================
// Package     : vga_pkg
// Description : Shared VGA pipeline widths, colours and bus bundles.
// Revision    : 1.0 - initial release
// =============================================================================
package vga_pkg;

    localparam int c_timing_w = 11;
    localparam int c_rgb_w    = 12;
    localparam int c_char_w   = 8;

    localparam logic [c_rgb_w-1:0] c_text_colour = 12'h0_2_9;
    localparam logic [c_rgb_w-1:0] c_bg_colour   = 12'h0_0_0;

    typedef struct packed {
        logic [c_timing_w-1:0] hcount;
        logic [c_timing_w-1:0] vcount;
        logic                  hsync;
        logic                  hblnk;
        logic                  vsync;
        logic                  vblnk;
        logic [c_rgb_w-1:0]    rgb;
    } vga_bus_t;

    // Everything that must stay aligned with char_pixels through the ROM latency.
    typedef struct packed {
        vga_bus_t   bus;
        logic       in_box;
        logic [2:0] bit_idx;
    } text_pipe_t;

endpackage
`default_nettype wire

// File: rtl/delay.sv
`default_nettype none
// =============================================================================
// Module      : delay
// Description : Resettable CLK_DEL-stage register pipeline of WIDTH bits.
// Revision    : 1.0 - initial release
// =============================================================================
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_pipe [CLK_DEL];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dout = r_pipe[CLK_DEL-1];

endmodule
`default_nettype wire

// File: rtl/draw_text_box.sv
`default_nettype none
// =============================================================================
// Module      : draw_text_box
// Description : Scaled, blinking, optionally opaque text-grid overlay for VGA.
// Revision    : 1.0 - initial release
// =============================================================================
module draw_text_box
    import vga_pkg::*;
#(
    parameter logic [c_rgb_w-1:0] TEXT_COLOUR  = c_text_colour,
    parameter logic [c_rgb_w-1:0] BG_COLOUR    = c_bg_colour,
    parameter int                 COLS         = 16,
    parameter int                 ROWS         = 16,
    parameter int                 CHAR_W       = c_char_w,
    parameter int                 CHAR_H       = 16,
    parameter int                 SCALE_LOG2   = 0,
    parameter int                 ROM_LAT      = 2,
    parameter int                 BLINK_FRAMES = 30
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 text_en,
    input  logic                                 opaque,
    input  logic                                 blink_en,
    input  logic [c_timing_w-1:0]                pos_x,
    input  logic [c_timing_w-1:0]                pos_y,
    input  logic [c_timing_w-1:0]                hcount_in,
    input  logic [c_timing_w-1:0]                vcount_in,
    input  logic                                 hsync_in,
    input  logic                                 hblnk_in,
    input  logic                                 vsync_in,
    input  logic                                 vblnk_in,
    input  logic [c_rgb_w-1:0]                   rgb_in,
    input  logic [7:0]                           char_pixels,
    output logic [c_timing_w-1:0]                hcount_out,
    output logic [c_timing_w-1:0]                vcount_out,
    output logic                                 hsync_out,
    output logic                                 hblnk_out,
    output logic                                 vsync_out,
    output logic                                 vblnk_out,
    output logic [c_rgb_w-1:0]                   rgb_out,
    output logic [$clog2(COLS)+$clog2(ROWS)-1:0] char_xy,
    output logic [$clog2(CHAR_H)-1:0]            char_line
);

    localparam int          c_xw    = $clog2(COLS);
    localparam int          c_yw    = $clog2(ROWS);
    localparam int          c_lw    = $clog2(CHAR_H);
    localparam int          c_cnt_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned c_box_w = (COLS * CHAR_W) << SCALE_LOG2;
    localparam int unsigned c_box_h = (ROWS * CHAR_H) << SCALE_LOG2;

    logic                  r_vsync_prev;
    logic                  r_text_en;
    logic                  r_opaque;
    logic                  r_blink_en;
    logic                  r_phase;
    logic [c_timing_w-1:0] r_px;
    logic [c_timing_w-1:0] r_py;
    logic [c_cnt_w-1:0]    r_frame_cnt;
    logic                  w_vs_rise;

    assign w_vs_rise = vsync_in & ~r_vsync_prev;

    // Per-frame settings and blink phase only move on a vsync rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_prev <= 1'b0;
            r_text_en    <= 1'b0;
            r_opaque     <= 1'b0;
            r_blink_en   <= 1'b0;
            r_px         <= '0;
            r_py         <= '0;
            r_frame_cnt  <= '0;
            r_phase      <= 1'b1;
        end else begin
            r_vsync_prev <= vsync_in;
            if (w_vs_rise) begin
                r_text_en  <= text_en;
                r_opaque   <= opaque;
                r_blink_en <= blink_en;
                r_px       <= pos_x;
                r_py       <= pos_y;
                if (r_frame_cnt == c_cnt_w'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    logic [c_timing_w-1:0] w_dx;
    logic [c_timing_w-1:0] w_dy;
    logic                  w_in_box;
    logic [2:0]            w_bit_idx;

    assign w_dx = hcount_in - r_px;
    assign w_dy = vcount_in - r_py;

    // The >= guards stop a box that runs past 2047 from wrapping onto the left/top edge.
    assign w_in_box  = (hcount_in >= r_px) && (32'(w_dx) < c_box_w) &&
                       (vcount_in >= r_py) && (32'(w_dy) < c_box_h);
    assign w_bit_idx = ~w_dx[SCALE_LOG2 +: 3];

    always_ff @(posedge clk) begin
        if (rst) begin
            char_xy   <= '0;
            char_line <= '0;
        end else begin
            char_xy   <= {w_dx[SCALE_LOG2+3 +: c_xw], w_dy[SCALE_LOG2+c_lw +: c_yw]};
            char_line <= w_dy[SCALE_LOG2 +: c_lw];
        end
    end

    text_pipe_t w_pipe_in;
    text_pipe_t w_pipe_out;

    assign w_pipe_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in,
                        rgb_in, w_in_box, w_bit_idx};

    delay #(
        .WIDTH   ($bits(text_pipe_t)),
        .CLK_DEL (ROM_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (w_pipe_in),
        .dout (w_pipe_out)
    );

    logic               w_draw;
    logic               w_set;
    logic [c_rgb_w-1:0] w_rgb;

    always_comb begin
        w_draw = w_pipe_out.in_box & r_text_en & ~w_pipe_out.bus.hblnk & ~w_pipe_out.bus.vblnk;
        w_set  = char_pixels[w_pipe_out.bit_idx] & ~(r_blink_en & ~r_phase);
        w_rgb  = w_pipe_out.bus.rgb;
        if (w_draw) begin
            if (w_set) begin
                w_rgb = TEXT_COLOUR;
            end else if (r_opaque) begin
                w_rgb = BG_COLOUR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= w_pipe_out.bus.hcount;
            vcount_out <= w_pipe_out.bus.vcount;
            hsync_out  <= w_pipe_out.bus.hsync;
            hblnk_out  <= w_pipe_out.bus.hblnk;
            vsync_out  <= w_pipe_out.bus.vsync;
            vblnk_out  <= w_pipe_out.bus.vblnk;
            rgb_out    <= w_rgb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_text_box.sv
`default_nettype none
// =============================================================================
// Module      : tb_draw_text_box
// Description : Scoreboard bench for draw_text_box (scale 1 and scale 2 instances).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_draw_text_box;

    localparam int BF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        text_en = 1'b0, opaque = 1'b0, blink_en = 1'b0;
    logic [10:0] pos_x = '0, pos_y = '0, hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [7:0]  char_pixels = '0;

    logic [10:0] hcount_out0, vcount_out0, hcount_out1, vcount_out1;
    logic        hsync_out0, hblnk_out0, vsync_out0, vblnk_out0;
    logic        hsync_out1, hblnk_out1, vsync_out1, vblnk_out1;
    logic [11:0] rgb_out0, rgb_out1;
    logic [7:0]  char_xy0, char_xy1;
    logic [3:0]  char_line0, char_line1;
    logic [25:0] tim0, tim1;

    assign tim0 = {hcount_out0, vcount_out0, hsync_out0, hblnk_out0, vsync_out0, vblnk_out0};
    assign tim1 = {hcount_out1, vcount_out1, hsync_out1, hblnk_out1, vsync_out1, vblnk_out1};

    draw_text_box #(.BLINK_FRAMES(BF)) u_dut0 (
        .clk(clk), .rst(rst), .text_en(text_en), .opaque(opaque), .blink_en(blink_en),
        .pos_x(pos_x), .pos_y(pos_y), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixels(char_pixels),
        .hcount_out(hcount_out0), .vcount_out(vcount_out0), .hsync_out(hsync_out0),
        .hblnk_out(hblnk_out0), .vsync_out(vsync_out0), .vblnk_out(vblnk_out0),
        .rgb_out(rgb_out0), .char_xy(char_xy0), .char_line(char_line0)
    );

    draw_text_box #(.SCALE_LOG2(1), .BLINK_FRAMES(BF)) u_dut1 (
        .clk(clk), .rst(rst), .text_en(text_en), .opaque(opaque), .blink_en(blink_en),
        .pos_x(pos_x), .pos_y(pos_y), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixels(char_pixels),
        .hcount_out(hcount_out1), .vcount_out(vcount_out1), .hsync_out(hsync_out1),
        .hblnk_out(hblnk_out1), .vsync_out(vsync_out1), .vblnk_out(vblnk_out1),
        .rgb_out(rgb_out1), .char_xy(char_xy1), .char_line(char_line1)
    );

    typedef struct {
        int          due;
        logic [11:0] rgb0;
        logic [11:0] rgb1;
        logic [25:0] tim;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model of the frame-latched state.
    int m_px, m_py, m_cnt;
    bit m_text, m_opq, m_blink, m_phase, m_vsp;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_reset();
        m_px = 0; m_py = 0; m_cnt = 0;
        m_text = 0; m_opq = 0; m_blink = 0; m_phase = 1; m_vsp = 0;
    endfunction

    function automatic logic [11:0] model_rgb(input int h, input int v, input bit hb, input bit vb,
                                              input logic [11:0] rgb, input logic [7:0] cp,
                                              input int s);
        int bw, bh, col;
        bw = 128 << s;
        bh = 256 << s;
        if (hb || vb || !m_text) return rgb;
        if (h < m_px || v < m_py || h - m_px >= bw || v - m_py >= bh) return rgb;
        col = ((h - m_px) >> s) % 8;
        if (cp[7 - col] && !(m_blink && !m_phase)) return 12'h029;
        if (m_opq) return 12'h000;
        return rgb;
    endfunction

    task automatic drive(input int h, input int v, input bit hs, input bit hb, input bit vs,
                         input bit vb, input int nx = -1, input int ny = -1);
        exp_t e;
        @(posedge clk); #1;
        if (nx >= 0) pos_x = 11'(nx);
        if (ny >= 0) pos_y = 11'(ny);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        hblnk_in  = hb;
        vsync_in  = vs;
        vblnk_in  = vb;
        rgb_in    = 12'($urandom_range(1, 4095));
        e.due  = cyc + 3;
        e.rgb0 = model_rgb(h, v, hb, vb, rgb_in, char_pixels, 0);
        e.rgb1 = model_rgb(h, v, hb, vb, rgb_in, char_pixels, 1);
        e.tim  = {hcount_in, vcount_in, hs, hb, vs, vb};
        q.push_back(e);
        if (vs && !m_vsp) begin
            m_text = text_en; m_opq = opaque; m_blink = blink_en;
            m_px = int'(pos_x); m_py = int'(pos_y);
            if (m_cnt == BF - 1) begin
                m_cnt = 0;
                m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
        end
        m_vsp = vs;
    endtask

    task automatic frame_pulse(input int nx = -1, input int ny = -1);
        for (int i = 0; i < 3; i++) drive(900, 700, 0, 1, 0, 1);
        drive(900, 701, 0, 1, 1, 1, nx, ny);
        drive(900, 702, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) drive(900, 703, 0, 1, 0, 1);
    endtask

    task automatic row(input int v, input int h0, input int h1, input bit vb = 0);
        for (int h = h0; h <= h1; h++) drive(h, v, 0, 0, 0, vb);
        drive(h1 + 1, v, 1, 1, 0, vb);
        drive(h1 + 2, v, 0, 1, 0, vb);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk); #1;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs never appeared, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic pulse_reset();
        drain();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        model_reset();
        q.delete();
    endtask

    // Scoreboard: each expectation is popped exactly on its due cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_checks += 3;
            if (e.due != cyc) begin
                n_fail++;
                $display("FAIL sb_late: entry due %0d seen at %0d", e.due, cyc);
            end
            if (rgb_out0 !== e.rgb0) begin
                n_fail++;
                $display("FAIL rgb_s0: h=%0d v=%0d got %h want %h", e.tim[25:15], e.tim[14:4], rgb_out0, e.rgb0);
            end
            if (rgb_out1 !== e.rgb1) begin
                n_fail++;
                $display("FAIL rgb_s1: h=%0d v=%0d got %h want %h", e.tim[25:15], e.tim[14:4], rgb_out1, e.rgb1);
            end
            if (tim0 !== e.tim || tim1 !== e.tim) begin
                n_fail++;
                $display("FAIL timing: got %h / %h want %h", tim0, tim1, e.tim);
            end
        end
    end

    task automatic test_reset();
        text_en = 1; pos_x = 11'd50; pos_y = 11'd50;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (rgb_out0 !== 12'h0 || rgb_out1 !== 12'h0) begin
            n_fail++; $display("FAIL reset_rgb: got %h %h want 000", rgb_out0, rgb_out1);
        end
        if (tim0 !== 26'h0 || tim1 !== 26'h0) begin
            n_fail++; $display("FAIL reset_timing: got %h %h want 0", tim0, tim1);
        end
        if (char_xy0 !== 8'h0 || char_xy1 !== 8'h0) begin
            n_fail++; $display("FAIL reset_char_xy: got %h %h want 00", char_xy0, char_xy1);
        end
        if (char_line0 !== 4'h0 || char_line1 !== 4'h0) begin
            n_fail++; $display("FAIL reset_char_line: got %h %h want 0", char_line0, char_line1);
        end
        @(posedge clk); #1; rst = 1'b0;
        model_reset();
        char_pixels = 8'hFF;
        row(60, 45, 70);
        drain();
    endtask

    task automatic test_basic();
        text_en = 1; opaque = 0; blink_en = 0; char_pixels = 8'h80;
        pos_x = 11'd50; pos_y = 11'd50;
        frame_pulse();
        row(49, 45, 185);
        row(50, 45, 185);
        row(51, 40, 185);
        row(177, 45, 185);
        row(305, 45, 185);
        row(306, 45, 185);
        drain();
    endtask

    task automatic test_scale();
        char_pixels = 8'hC0;
        pos_x = 11'd50; pos_y = 11'd50;
        frame_pulse();
        row(50, 45, 90);
        row(82, 45, 90);
        drive(66, 50, 0, 0, 0, 0);
        drive(50, 82, 0, 0, 0, 0);
        n_checks += 2;
        if (char_xy0 !== 8'h20 || char_line0 !== 4'd0) begin
            n_fail++; $display("FAIL xy_s0_h66: got %h/%0d want 20/0", char_xy0, char_line0);
        end
        if (char_xy1 !== 8'h10 || char_line1 !== 4'd0) begin
            n_fail++; $display("FAIL xy_s1_h66: got %h/%0d want 10/0", char_xy1, char_line1);
        end
        drive(60, 57, 0, 0, 0, 0);
        n_checks += 2;
        if (char_xy0 !== 8'h02 || char_line0 !== 4'd0) begin
            n_fail++; $display("FAIL xy_s0_v82: got %h/%0d want 02/0", char_xy0, char_line0);
        end
        if (char_xy1 !== 8'h01 || char_line1 !== 4'd0) begin
            n_fail++; $display("FAIL xy_s1_v82: got %h/%0d want 01/0", char_xy1, char_line1);
        end
        drive(61, 57, 1, 1, 0, 0);
        n_checks += 2;
        if (char_xy0 !== 8'h10 || char_line0 !== 4'd7) begin
            n_fail++; $display("FAIL xy_s0_line: got %h/%0d want 10/7", char_xy0, char_line0);
        end
        if (char_xy1 !== 8'h00 || char_line1 !== 4'd3) begin
            n_fail++; $display("FAIL xy_s1_line: got %h/%0d want 00/3", char_xy1, char_line1);
        end
        drain();
    endtask

    task automatic test_opaque();
        opaque = 1; char_pixels = 8'h00;
        frame_pulse();
        row(49, 45, 182);
        row(50, 45, 182);
        row(200, 45, 182);
        for (int h = 45; h < 70; h++) drive(h, 201, 0, 1, 0, 0);
        row(202, 45, 70, 1);
        row(305, 45, 182);
        row(306, 45, 182);
        opaque = 0;
        drain();
    endtask

    task automatic test_pos_change();
        char_pixels = 8'h80; pos_x = 11'd50; pos_y = 11'd50;
        frame_pulse();
        row(60, 40, 110);
        pos_x = 11'd100;
        row(61, 40, 110);
        frame_pulse(-1, 70);
        row(69, 90, 240);
        row(70, 40, 240);
        drain();
    endtask

    task automatic test_blink();
        pulse_reset();
        text_en = 1; opaque = 1; blink_en = 1; char_pixels = 8'h80;
        pos_x = 11'd50; pos_y = 11'd50;
        for (int f = 1; f <= 5; f++) begin
            frame_pulse();
            row(60, 45, 100);
        end
        blink_en = 0; opaque = 0;
        drain();
    endtask

    task automatic test_reset_mid();
        int k;
        text_en = 1; char_pixels = 8'h80; pos_x = 11'd50; pos_y = 11'd50;
        frame_pulse();
        for (int h = 40; h < 60; h++) drive(h, 60, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1; hcount_in = 11'd60; vcount_in = 11'd60; hblnk_in = 0; vblnk_in = 0;
        rgb_in = 12'h5A5;
        k = cyc;
        while (q.size() > 0 && q[$].due > k) void'(q.pop_back());
        model_reset();
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (rgb_out0 !== 12'h0 || rgb_out1 !== 12'h0 || tim0 !== 26'h0 || tim1 !== 26'h0) begin
                n_fail++;
                $display("FAIL midreset_zero_%0d: rgb %h %h tim %h %h want 0", i, rgb_out0, rgb_out1, tim0, tim1);
            end
        end
        @(negedge clk);
        n_checks++;
        if (rgb_out0 !== 12'h5A5 || rgb_out1 !== 12'h5A5 || hcount_out0 !== 11'd60) begin
            n_fail++;
            $display("FAIL midreset_resume: rgb %h %h h=%0d want 5a5 at h=60", rgb_out0, rgb_out1, hcount_out0);
        end
        row(61, 45, 80);
        frame_pulse();
        row(62, 45, 80);
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_scale();
        test_opaque();
        test_pos_change();
        test_blink();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
